// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer for the 16-bit CPU.
// It issues every datapath strobe from the current state.
// A wait counter guards each memory request/acknowledge handshake.
module control_sequencer #(
   parameter int ALU_OPCODE  = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  iclk,
   input  logic                  irst_n,
   input  logic                  run,
   input  logic [ALU_OPCODE:0]   opcode,
   input  logic                  zflag,
   input  logic                  cflag,
   input  logic                  mem_ack,
   output logic                  loadIR,
   output logic                  incPC,
   output logic                  loadPC,
   output logic                  loadMAR,
   output logic                  selMAR,
   output logic                  memRD,
   output logic                  memWR,
   output logic                  loadA,
   output logic                  aluEn,
   output logic [ALU_OPCODE:0]   aluOp,
   output logic                  loadOUT,
   output logic                  halted,
   output logic                  fault,
   output logic [3:0]            state
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_FETCH_ADDR = 4'd1,
      S_FETCH_MEM  = 4'd2,
      S_FETCH_LOAD = 4'd3,
      S_DECODE     = 4'd4,
      S_EXEC_ADDR  = 4'd5,
      S_EXEC_MEM   = 4'd6,
      S_EXEC_WB    = 4'd7,
      S_EXEC_JUMP  = 4'd8,
      S_EXEC_OUT   = 4'd9,
      S_HALT       = 4'd10,
      S_FAULT      = 4'd11
   } state_t;

   localparam int OPW = ALU_OPCODE + 1;
   localparam logic [ALU_OPCODE:0] OP_NOP = OPW'(5'b00000);
   localparam logic [ALU_OPCODE:0] OP_LDA = OPW'(5'b00001);
   localparam logic [ALU_OPCODE:0] OP_STA = OPW'(5'b00010);
   localparam logic [ALU_OPCODE:0] OP_ADD = OPW'(5'b00011);
   localparam logic [ALU_OPCODE:0] OP_SUB = OPW'(5'b00100);
   localparam logic [ALU_OPCODE:0] OP_AND = OPW'(5'b00101);
   localparam logic [ALU_OPCODE:0] OP_OR  = OPW'(5'b00110);
   localparam logic [ALU_OPCODE:0] OP_XOR = OPW'(5'b00111);
   localparam logic [ALU_OPCODE:0] OP_JMP = OPW'(5'b01000);
   localparam logic [ALU_OPCODE:0] OP_JZ  = OPW'(5'b01001);
   localparam logic [ALU_OPCODE:0] OP_JC  = OPW'(5'b01010);
   localparam logic [ALU_OPCODE:0] OP_OUT = OPW'(5'b01011);
   localparam logic [ALU_OPCODE:0] OP_HLT = OPW'(5'b11111);

   // The memory state is abandoned on the cycle its wait count would reach this value.
   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   state_t     state_r;
   state_t     state_s;
   logic [7:0] wait_r;
   logic [7:0] wait_s;

   // State and wait counter registers; reset returns to IDLE at once.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_r <= S_IDLE;
         wait_r  <= 8'd0;
      end else begin
         state_r <= state_s;
         wait_r  <= wait_s;
      end
   end

   // Next-state logic; the wait counter only runs while in a memory state.
   always_comb begin
      state_s = state_r;
      wait_s  = 8'd0;
      case (state_r)
         S_IDLE: begin
            if (run) state_s = S_FETCH_ADDR;
            else     state_s = S_IDLE;
         end
         S_FETCH_ADDR: state_s = S_FETCH_MEM;
         S_FETCH_MEM: begin
            if (mem_ack) begin
               state_s = S_FETCH_LOAD;
            end else if ((wait_r + 8'd1) == TIMEOUT_C) begin
               state_s = S_FAULT;
            end else begin
               state_s = S_FETCH_MEM;
               wait_s  = wait_r + 8'd1;
            end
         end
         S_FETCH_LOAD: state_s = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_NOP: state_s = S_FETCH_ADDR;
               OP_HLT: state_s = S_HALT;
               OP_JMP: state_s = S_EXEC_JUMP;
               OP_JZ: begin
                  if (zflag) state_s = S_EXEC_JUMP;
                  else       state_s = S_FETCH_ADDR;
               end
               OP_JC: begin
                  if (cflag) state_s = S_EXEC_JUMP;
                  else       state_s = S_FETCH_ADDR;
               end
               OP_OUT: state_s = S_EXEC_OUT;
               OP_LDA, OP_STA, OP_ADD, OP_SUB,
               OP_AND, OP_OR, OP_XOR: state_s = S_EXEC_ADDR;
               default: state_s = S_FAULT;
            endcase
         end
         S_EXEC_ADDR: state_s = S_EXEC_MEM;
         S_EXEC_MEM: begin
            if (mem_ack) begin
               if (opcode == OP_STA) state_s = S_FETCH_ADDR;
               else                  state_s = S_EXEC_WB;
            end else if ((wait_r + 8'd1) == TIMEOUT_C) begin
               state_s = S_FAULT;
            end else begin
               state_s = S_EXEC_MEM;
               wait_s  = wait_r + 8'd1;
            end
         end
         S_EXEC_WB:   state_s = S_FETCH_ADDR;
         S_EXEC_JUMP: state_s = S_FETCH_ADDR;
         S_EXEC_OUT:  state_s = S_FETCH_ADDR;
         S_HALT:      state_s = S_HALT;
         S_FAULT:     state_s = S_FAULT;
         default:     state_s = S_FAULT;
      endcase
   end

   // Moore output decode from the state register; aluOp forwards the opcode in write-back.
   always_comb begin
      loadIR  = 1'b0;
      incPC   = 1'b0;
      loadPC  = 1'b0;
      loadMAR = 1'b0;
      selMAR  = 1'b0;
      memRD   = 1'b0;
      memWR   = 1'b0;
      loadA   = 1'b0;
      aluEn   = 1'b0;
      aluOp   = '0;
      loadOUT = 1'b0;
      halted  = 1'b0;
      fault   = 1'b0;
      case (state_r)
         S_FETCH_ADDR: loadMAR = 1'b1;
         S_FETCH_MEM:  memRD = 1'b1;
         S_FETCH_LOAD: begin
            loadIR = 1'b1;
            incPC  = 1'b1;
         end
         S_EXEC_ADDR: begin
            loadMAR = 1'b1;
            selMAR  = 1'b1;
         end
         S_EXEC_MEM: begin
            if (opcode == OP_STA) memWR = 1'b1;
            else                  memRD = 1'b1;
         end
         S_EXEC_WB: begin
            loadA = 1'b1;
            if (opcode != OP_LDA) begin
               aluEn = 1'b1;
               aluOp = opcode;
            end else begin
               aluEn = 1'b0;
               aluOp = '0;
            end
         end
         S_EXEC_JUMP: loadPC = 1'b1;
         S_EXEC_OUT:  loadOUT = 1'b1;
         S_HALT:      halted = 1'b1;
         S_FAULT:     fault = 1'b1;
         default:     loadMAR = 1'b0;
      endcase
   end

   assign state = state_r;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: plans the state trace of each instruction from the
// opcode, flags and chosen ack delays, drives mem_ack from that plan and
// compares every DUT output against the planned state on each falling edge.
module tb_control_sequencer;

   localparam int T = 15;

   logic       iclk = 1'b0;
   logic       irst_n = 1'b1;
   logic       run = 1'b0;
   logic [4:0] opcode = 5'd0;
   logic       zflag = 1'b0;
   logic       cflag = 1'b0;
   logic       mem_ack = 1'b0;
   logic       loadIR, incPC, loadPC, loadMAR, selMAR, memRD, memWR;
   logic       loadA, aluEn, loadOUT, halted, fault;
   logic [4:0] aluOp;
   logic [3:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_state = 0;
   int exp_op    = 0;
   bit chk_en    = 1'b0;

   int pst[$];
   bit pack[$];
   bit term;
   int cnt_rd6, cnt_wr, cnt_pc, cnt_la, cnt_s2, cnt_h, wb_aluop;

   control_sequencer #(.ALU_OPCODE(4), .MEM_TIMEOUT(T)) dut (
      .iclk(iclk), .irst_n(irst_n), .run(run), .opcode(opcode),
      .zflag(zflag), .cflag(cflag), .mem_ack(mem_ack),
      .loadIR(loadIR), .incPC(incPC), .loadPC(loadPC), .loadMAR(loadMAR),
      .selMAR(selMAR), .memRD(memRD), .memWR(memWR), .loadA(loadA),
      .aluEn(aluEn), .aluOp(aluOp), .loadOUT(loadOUT), .halted(halted),
      .fault(fault), .state(state)
   );

   always #5 iclk = ~iclk;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   // Expected strobes for a state: {loadIR,incPC,loadPC,loadMAR,selMAR,memRD,memWR,loadA,aluEn,loadOUT,halted,fault}
   function automatic logic [11:0] exp_strb(input int s, input int op);
      exp_strb = {s == 3, s == 3, s == 8, (s == 1) || (s == 5), s == 5,
                  (s == 2) || ((s == 6) && (op != 2)), (s == 6) && (op == 2),
                  s == 7, (s == 7) && (op != 1), s == 9, s == 10, s == 11};
   endfunction

   function automatic int exp_aluop(input int s, input int op);
      exp_aluop = ((s == 7) && (op != 1)) ? op : 0;
   endfunction

   // Single compare process: DUT outputs against the planned state each falling edge.
   always @(negedge iclk) begin
      if (chk_en) begin
         check("state", int'(state), exp_state);
         check("strobes", int'({loadIR, incPC, loadPC, loadMAR, selMAR, memRD, memWR,
                                loadA, aluEn, loadOUT, halted, fault}),
               int'(exp_strb(exp_state, exp_op)));
         check("aluOp", int'(aluOp), exp_aluop(exp_state, exp_op));
      end
   end

   task automatic push(input int s, input bit a);
      pst.push_back(s);
      pack.push_back(a);
   endtask

   // d = cycles without ack before the ack; d >= T means the ack never comes in time.
   task automatic add_mem(input int s, input int d);
      if (d >= T) begin
         repeat (T) push(s, 1'b0);
         push(11, 1'b0);
         term = 1'b1;
      end else begin
         repeat (d) push(s, 1'b0);
         push(s, 1'b1);
      end
   endtask

   // Build the expected per-cycle state trace of one instruction, starting in FETCH_ADDR.
   task automatic build(input int op, input bit z, input bit c, input int df, input int de);
      pst.delete();
      pack.delete();
      term = 1'b0;
      push(1, 1'($urandom));
      add_mem(2, df);
      if (!term) begin
         push(3, 1'($urandom));
         push(4, 1'($urandom));
         case (op)
            0:  ;
            31: begin push(10, 1'($urandom)); term = 1'b1; end
            8:  push(8, 1'($urandom));
            9:  if (z) push(8, 1'($urandom));
            10: if (c) push(8, 1'($urandom));
            11: push(9, 1'($urandom));
            1, 2, 3, 4, 5, 6, 7: begin
               push(5, 1'($urandom));
               add_mem(6, de);
               if (!term && (op != 2)) push(7, 1'($urandom));
            end
            default: begin push(11, 1'($urandom)); term = 1'b1; end
         endcase
      end
   endtask

   // Drive the planned trace; optionally pull reset low between edges at index rst_idx.
   task automatic run_plan(input int op, input bit z, input bit c, input int rst_idx);
      cnt_rd6 = 0; cnt_wr = 0; cnt_pc = 0; cnt_la = 0; cnt_s2 = 0; wb_aluop = -1;
      foreach (pst[i]) begin
         @(posedge iclk);
         #1;
         exp_state = pst[i];
         exp_op    = op;
         mem_ack   = pack[i];
         opcode    = (pst[i] >= 4) ? 5'(op) : 5'($urandom);
         zflag     = (pst[i] == 4) ? z : 1'($urandom);
         cflag     = (pst[i] == 4) ? c : 1'($urandom);
         run       = 1'($urandom);
         if (memRD && (state == 4'd6)) cnt_rd6++;
         if (memWR)  cnt_wr++;
         if (loadPC) cnt_pc++;
         if (loadA)  cnt_la++;
         if (state == 4'd2) cnt_s2++;
         if (state == 4'd7) wb_aluop = int'(aluOp);
         if (i == rst_idx) begin
            #2;
            irst_n    = 1'b0;
            exp_state = 0;
            #1;
            check("rst_async_state", int'(state), 0);
            check("rst_async_memrd", int'(memRD), 0);
            return;
         end
      end
   endtask

   task automatic hold(input int n, input int s);
      repeat (n) begin
         @(posedge iclk);
         #1;
         exp_state = s;
         run       = 1'($urandom);
         mem_ack   = 1'($urandom);
         opcode    = 5'($urandom);
         zflag     = 1'($urandom);
         cflag     = 1'($urandom);
         if (halted) cnt_h++;
      end
   endtask

   // Reset (unless already low), release away from the edge, idle, then pulse run.
   task automatic do_reset(input bit already_low);
      if (!already_low) begin
         @(posedge iclk);
         #2;
         irst_n    = 1'b0;
         exp_state = 0;
      end
      @(posedge iclk);
      #1;
      exp_state = 0;
      run       = 1'b1;
      @(posedge iclk);
      #1;
      irst_n = 1'b1;
      run    = 1'b0;
      repeat (2) begin
         @(posedge iclk);
         #1;
         exp_state = 0;
         run       = 1'b0;
         mem_ack   = 1'($urandom);
      end
      @(posedge iclk);
      #1;
      exp_state = 0;
      run       = 1'b1;
   endtask

   function automatic bit legal(input int v);
      legal = (v <= 11) || (v == 31);
   endfunction

   initial begin
      int op, df, de, r;
      bit z, c;
      #1;
      irst_n = 1'b0;
      #14;
      check("reset_state", int'(state), 0);
      check("reset_outputs", int'({loadIR, incPC, loadMAR, memRD, halted, fault, aluOp}), 0);
      chk_en = 1'b1;
      do_reset(1'b1);

      build(0, 1'b0, 1'b0, 0, 0);
      check("nop_len", pst.size(), 4);
      run_plan(0, 1'b0, 1'b0, -1);

      build(3, 1'b0, 1'b0, 0, 3);
      check("add_len", pst.size(), 10);
      run_plan(3, 1'b0, 1'b0, -1);
      check("add_memrd_cycles", cnt_rd6, 4);
      check("add_loada", cnt_la, 1);
      check("add_aluop", wb_aluop, 3);

      build(9, 1'b0, 1'b0, 0, 0);
      check("jz_nt_len", pst.size(), 4);
      run_plan(9, 1'b0, 1'b0, -1);
      check("jz_nt_loadpc", cnt_pc, 0);
      build(9, 1'b1, 1'b0, 0, 0);
      check("jz_t_len", pst.size(), 5);
      run_plan(9, 1'b1, 1'b0, -1);
      check("jz_t_loadpc", cnt_pc, 1);

      build(2, 1'b0, 1'b0, 0, 0);
      check("sta_len", pst.size(), 6);
      run_plan(2, 1'b0, 1'b0, -1);
      check("sta_memwr", cnt_wr, 1);
      check("sta_memrd", cnt_rd6, 0);
      check("sta_loada", cnt_la, 0);

      build(4, 1'b0, 1'b0, 0, T - 1);
      check("ack_last_cycle_len", pst.size(), 21);
      run_plan(4, 1'b0, 1'b0, -1);

      build(31, 1'b0, 1'b0, 0, 0);
      run_plan(31, 1'b0, 1'b0, -1);
      cnt_h = 0;
      hold(20, 10);
      check("halt_held", cnt_h, 20);
      do_reset(1'b0);

      build(0, 1'b0, 1'b0, T, 0);
      run_plan(0, 1'b0, 1'b0, -1);
      check("timeout_wait_cycles", cnt_s2, 15);
      hold(3, 11);
      check("timeout_fault", int'(fault), 1);
      do_reset(1'b0);

      build(21, 1'b0, 1'b0, 1, 0);
      run_plan(21, 1'b0, 1'b0, -1);
      hold(3, 11);
      do_reset(1'b0);

      build(1, 1'b0, 1'b0, 0, 10);
      run_plan(1, 1'b0, 1'b0, 7);
      do_reset(1'b1);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 39);
         if (r < 38) begin
            op = $urandom_range(0, 11);
         end else if (r == 38) begin
            op = 31;
         end else begin
            do op = $urandom_range(0, 31); while (legal(op));
         end
         r  = $urandom_range(0, 39);
         df = (r < 34) ? (r % 4) : ((r < 38) ? (T - 1) : T);
         r  = $urandom_range(0, 39);
         de = (r < 34) ? (r % 5) : ((r < 38) ? (T - 1) : T + 2);
         z  = 1'($urandom);
         c  = 1'($urandom);
         build(op, z, c, df, de);
         run_plan(op, z, c, -1);
         if (term) begin
            hold($urandom_range(2, 6), pst[pst.size() - 1]);
            do_reset(1'b0);
         end
      end

      @(posedge iclk);
      #1;
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
